// File: rtl/shift_pkg.sv
// Shared constants for the sequential shifter: widths, op codes and FSM encodings.
// ROR support is compiled in only when SHIFT_ROTATE_EN is defined.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 3;
  localparam int STATE_W = 2;

  localparam logic [OP_W-1:0] SHOP_PASS = 3'b000;
  localparam logic [OP_W-1:0] SHOP_SLL  = 3'b001;
  localparam logic [OP_W-1:0] SHOP_SRL  = 3'b010;
  localparam logic [OP_W-1:0] SHOP_SRA  = 3'b011;
  localparam logic [OP_W-1:0] SHOP_ROR  = 3'b100;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;
  typedef logic [OP_W-1:0]    shop_t;

  // Anything not listed here degrades to a pass-through.
  function automatic logic shop_supported(input shop_t op);
    logic ok;
    ok = 1'b0;
    case (op)
      SHOP_SLL, SHOP_SRL, SHOP_SRA: ok = 1'b1;
`ifdef SHIFT_ROTATE_EN
      SHOP_ROR:                     ok = 1'b1;
`endif
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step: maps (op, value) to the value after one shift.
// Rotate-right is only decoded when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (shop_supported(op)) begin
      case (op)
        SHOP_SLL: next_value = {value[DATA_W-2:0], 1'b0};
        SHOP_SRL: next_value = {1'b0, value[DATA_W-1:1]};
        SHOP_SRA: next_value = {value[DATA_W-1], value[DATA_W-1:1]};
`ifdef SHIFT_ROTATE_EN
        SHOP_ROR: next_value = {value[0], value[DATA_W-1:1]};
`endif
        default:  next_value = value;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: one bit per clock, done pulse after shamt shifts.
// Define SHIFT_ROTATE_EN to enable rotate-right (op=100); otherwise it passes through.
module shift_seq_unit
  import shift_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   result,
  output logic                busy,
  output logic                done
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  step_value;

  shift_step u_step (
    .op         (op_q),
    .value      (result_q),
    .next_value (step_value)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = data_in;
          count_d  = shamt;
          op_d     = op;
          state_d  = (shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        result_d = step_value;
        count_d  = count_q - 1'b1;
        // Last shift happens on the edge that takes count from 1 to 0.
        if (count_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= SHOP_PASS;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: directed corner cases plus random back-to-back traffic.
// Honours SHIFT_ROTATE_EN the same way the design does.
module tb_shift_seq_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  shift_seq_unit dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    int          edge_n;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          edge_cnt = 0;
  logic [31:0] last_exp = 32'd0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Reference: whole-word shift by the full amount, no per-bit stepping.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [5:0] s, input logic [31:0] d);
    case (o)
      3'd1: return d << s;
      3'd2: return d >> s;
      3'd3: return 32'($signed(d) >>> s);
`ifdef SHIFT_ROTATE_EN
      3'd4: return (d >> s) | (d << (6'd32 - s));
`endif
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d required no done", edge_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.tag, "_result"}, result, mon_e.res);
        chk({mon_e.tag, "_done_edge"}, edge_cnt, mon_e.edge_n);
      end
    end
  end

  // Call at a negedge with the DUT idle; start is sampled at the next posedge.
  task automatic issue(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d, input string tag);
    exp_t e;
    op      = o;
    shamt   = s;
    data_in = d;
    start   = 1'b1;
    e.res    = model(o, {1'b0, s}, d);
    e.edge_n = edge_cnt + 1 + int'(s);
    e.tag    = tag;
    exp_q.push_back(e);
    last_exp = e.res;
  endtask

  task automatic wait_done(input bit glitch, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (i == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
      end else if (glitch && i == 2 && busy) begin
        start   = 1'b1;
        op      = 3'($urandom_range(0, 7));
        shamt   = 5'($urandom_range(0, 31));
        data_in = $urandom;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done required done within 40 cycles", tag);
    end
  endtask

  // Leaves the bench at the idle negedge, ready for a back-to-back start.
  task automatic txn(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d,
                     input bit glitch, input string tag);
    issue(o, s, d, tag);
    wait_done(glitch, tag);
    @(negedge clock);
    chk({tag, "_hold"}, result, last_exp);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    txn(3'd1, 5'd4,  32'h0000_000F, 1'b0, "sll4");
    txn(3'd3, 5'd31, 32'h8000_0000, 1'b0, "sra31");
    txn(3'd2, 5'd31, 32'h8000_0000, 1'b0, "srl31");
    txn(3'd1, 5'd0,  32'h1234_5678, 1'b0, "shamt0");
    txn(3'd3, 5'd0,  32'hDEAD_BEEF, 1'b0, "shamt0b");
    txn(3'd2, 5'd8,  32'hA5A5_1234, 1'b1, "busy_start");
    txn(3'd4, 5'd4,  32'h0000_000F, 1'b0, "ror4");
    txn(3'd4, 5'd31, 32'h8000_0001, 1'b0, "ror31");
    txn(3'd5, 5'd7,  32'hCAFE_F00D, 1'b0, "undef5");
    txn(3'd7, 5'd3,  32'h0BAD_CAFE, 1'b0, "undef7");
    txn(3'd0, 5'd12, 32'h1357_9BDF, 1'b0, "pass12");

    // Abort a long shift with reset; no done may follow.
    issue(3'd1, 5'd10, 32'h0000_0001, "abort");
    repeat (3) @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("abort_result", result, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    chk("abort_quiet_busy", 32'(busy), 32'd0);

    txn(3'd3, 5'd5, 32'hF000_0000, 1'b0, "post_abort");

    for (int n = 0; n < 40; n++) begin
      txn(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 SHALL have port clock, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-003 SHALL have port start, input, 1, request to begin a shift; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3, shift operation code; sampled with start.
REQ-005 SHALL have port shamt, input, 5, shift amount 0..31; sampled with start.
REQ-006 SHALL have port data_in, input, 32, operand from the shift-source selector; sampled with start.
REQ-007 SHALL have port result, output, 32, shift register contents; final value valid when done=1.
REQ-008 SHALL have port busy, output, 1, high in SHIFT and DONE states.
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 SHALL, in IDLE with start=1, load result<=data_in, count<=shamt, latch op, and go to SHIFT if shamt!=0, else DONE.
REQ-012 SHALL, in SHIFT, apply one 1-bit shift per cycle to result, decrement count, and go to DONE when count reaches 0 in that cycle.
REQ-013 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-014 SHALL encode op: 000 pass, 001 SLL (zero fill), 010 SRL (zero fill), 011 SRA (sign fill from bit 31), 100 ROR (bit 0 into bit 31).
REQ-015 SHALL treat undefined op codes as pass: result equals data_in at done.
REQ-016 SHALL assert done exactly shamt+1 rising edges after the edge that sampled start; shamt=0 gives done 1 edge later.
REQ-017 SHALL ignore start while busy=1; the latched op, shamt and operand remain unchanged.
REQ-018 SHALL hold result stable from DONE until the next accepted start.
REQ-019 SHALL accept a new start in the cycle immediately following done (IDLE), with no extra gap.
REQ-020 SHALL keep all arithmetic 32-bit; shamt=31 SRA of 0x80000000 yields 0xFFFFFFFF.
REQ-021 SHALL make result intermediate values visible during SHIFT; consumers use them only on done.

Reset
REQ-022 SHALL, on reset=0 at a rising edge, set state=IDLE, result=0, count=0, latched op=000, busy=0, done=0.
REQ-023 SHALL abort any in-progress shift on reset; no done pulse follows the abort.
REQ-024 SHALL give reset priority over start in the same cycle.

Configuration
REQ-025 SHALL use macro SHIFT_ROTATE_EN to gate ROR support.
REQ-026 SHALL, with SHIFT_ROTATE_EN defined, perform ROR for op=100 per REQ-014.
REQ-027 SHALL, without SHIFT_ROTATE_EN, treat op=100 as undefined (pass per REQ-015); latency unchanged.

Structure
REQ-028 SHALL place op encodings (SHOP_PASS, SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_ROR), FSM state encodings and width constants (DATA_W=32, SHAMT_W=5) in shared package shift_pkg.
REQ-029 SHALL factor the combinational 1-bit step (op, value -> next value) into sub-module shift_step; the FSM, counter and registers remain in shift_seq_unit.

Verification
REQ-030 SHALL cover: reset low 2 cycles -> result=0, busy=0, done=0; start after release accepted.
REQ-031 SHALL cover: start, op=001, shamt=4, data_in=0x0000000F -> done at edge 5, result=0x000000F0.
REQ-032 SHALL cover: op=011, shamt=31, data_in=0x80000000 -> done at edge 32, result=0xFFFFFFFF; op=010 same inputs -> 0x00000001.
REQ-033 SHALL cover: shamt=0, op=001, data_in=0x12345678 -> done at edge 1, result=0x12345678; start pulsed again while busy in a shamt=8 shift -> ignored, single done.
REQ-034 SHALL cover: op=100, shamt=4, data_in=0x0000000F -> 0xF0000000 with SHIFT_ROTATE_EN, 0x0000000F without.
REQ-035 SHALL cover: reset asserted at cycle 3 of a shamt=10 shift -> IDLE, result=0, no done pulse; back-to-back starts on the cycle after done each complete correctly.
